// File: rtl/uncache_wbuf_if.sv
// rtl/uncache_wbuf_if.sv - CPU-side and AXI-side signal bundle for the uncached access buffer
interface uncache_wbuf_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LT_W   = 3
);
  logic                cpu_valid;
  logic                cpu_op;
  logic [ADDR_W-1:0]   cpu_addr;
  logic [DATA_W-1:0]   cpu_wdata;
  logic [DATA_W/8-1:0] cpu_wstrb;
  logic [LT_W-1:0]     cpu_loadType;
  logic                cpu_flush;
  logic                cpu_addr_ok;
  logic                cpu_data_ok;
  logic [DATA_W-1:0]   cpu_rdata;
  logic                rd_req;
  logic [ADDR_W-1:0]   rd_addr;
  logic [LT_W-1:0]     loadType;
  logic                rd_rdy;
  logic                ret_valid;
  logic [DATA_W-1:0]   ret_data;
  logic                wr_req;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] wr_wstrb;
  logic                wr_rdy;
  logic                wr_valid;
  logic                empty;

  modport slave (
    input  cpu_valid, cpu_op, cpu_addr, cpu_wdata, cpu_wstrb, cpu_loadType, cpu_flush,
    input  rd_rdy, ret_valid, ret_data, wr_rdy, wr_valid,
    output cpu_addr_ok, cpu_data_ok, cpu_rdata, rd_req, rd_addr, loadType,
    output wr_req, wr_addr, wr_data, wr_wstrb, empty
  );

  modport master (
    output cpu_valid, cpu_op, cpu_addr, cpu_wdata, cpu_wstrb, cpu_loadType, cpu_flush,
    output rd_rdy, ret_valid, ret_data, wr_rdy, wr_valid,
    input  cpu_addr_ok, cpu_data_ok, cpu_rdata, rd_req, rd_addr, loadType,
    input  wr_req, wr_addr, wr_data, wr_wstrb, empty
  );
endinterface

// File: rtl/uncache_wbuf.sv
// rtl/uncache_wbuf.sv - posted uncached store FIFO with in-order drain and serialised loads
// Optional store merging into the tail entry: define UNCACHE_WMERGE_EN.
module uncache_wbuf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LT_W   = 3
) (
  input logic clk,
  input logic rst,
  uncache_wbuf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = DATA_W / 8;

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_DONE} rstate_t;

  wstate_t w_state, w_next;
  rstate_t r_state, r_next;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [SW-1:0]     mem_strb [DEPTH];

  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       count;
  logic              full, pop, push, merge, store_ok, load_ok, is_empty;
  logic              st_ack, drop;
  logic [ADDR_W-1:0] ld_addr;
  logic [LT_W-1:0]   ld_type;
  logic [DATA_W-1:0] rdata;

  assign full     = (count == (AW+1)'(DEPTH));
  assign pop      = (w_state == W_WAIT) && bus.wr_valid;
  assign is_empty = (count == '0) && (w_state == W_IDLE);

`ifdef UNCACHE_WMERGE_EN
  localparam int BW = $clog2(SW);
  logic [AW-1:0] tail;
  assign tail  = wptr - AW'(1);
  // The head entry must not change once its write has been presented on the bus.
  assign merge = bus.cpu_valid && bus.cpu_op && !bus.cpu_flush && (r_state == R_IDLE) &&
                 (count != '0) && (mem_addr[tail][ADDR_W-1:BW] == bus.cpu_addr[ADDR_W-1:BW]) &&
                 !((tail == rptr) && (w_state != W_IDLE));
`else
  assign merge = 1'b0;
`endif

  assign store_ok = bus.cpu_valid && bus.cpu_op && !bus.cpu_flush && (r_state == R_IDLE) &&
                    (!full || pop || merge);
  assign push     = store_ok && !merge;
  assign load_ok  = bus.cpu_valid && !bus.cpu_op && !bus.cpu_flush && (r_state == R_IDLE) && is_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (count != '0)    w_next = W_REQ;
      W_REQ:   if (bus.wr_rdy)     w_next = W_WAIT;
      W_WAIT:  if (bus.wr_valid)   w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (load_ok) r_next = R_REQ;
      R_REQ: begin
        // Once rd_rdy is seen the read is on the bus and its response must be consumed.
        if (bus.rd_rdy)         r_next = R_WAIT;
        else if (bus.cpu_flush) r_next = R_IDLE;
      end
      R_WAIT:  if (bus.ret_valid) r_next = (drop || bus.cpu_flush) ? R_IDLE : R_DONE;
      R_DONE:  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    bus.wr_req      = (w_state == W_REQ);
    bus.wr_addr     = bus.wr_req ? mem_addr[rptr] : '0;
    bus.wr_data     = bus.wr_req ? mem_data[rptr] : '0;
    bus.wr_wstrb    = bus.wr_req ? mem_strb[rptr] : '0;
    bus.rd_req      = (r_state == R_REQ);
    bus.rd_addr     = ld_addr;
    bus.loadType    = ld_type;
    bus.cpu_addr_ok = store_ok || load_ok;
    bus.cpu_data_ok = (st_ack && !bus.cpu_flush) || (r_state == R_DONE);
    bus.cpu_rdata   = rdata;
    bus.empty       = is_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      st_ack  <= 1'b0;
      drop    <= 1'b0;
      ld_addr <= '0;
      ld_type <= '0;
      rdata   <= '0;
    end else begin
      st_ack <= store_ok;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (load_ok) begin
        ld_addr <= bus.cpu_addr;
        ld_type <= bus.cpu_loadType;
      end
      if ((r_state == R_REQ) && bus.rd_rdy)          drop <= bus.cpu_flush;
      else if ((r_state == R_WAIT) && bus.cpu_flush) drop <= 1'b1;
      if ((r_state == R_WAIT) && bus.ret_valid) rdata <= bus.ret_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wptr] <= bus.cpu_addr;
      mem_data[wptr] <= bus.cpu_wdata;
      mem_strb[wptr] <= bus.cpu_wstrb;
    end
`ifdef UNCACHE_WMERGE_EN
    if (store_ok && merge) begin
      for (int b = 0; b < SW; b++)
        if (bus.cpu_wstrb[b]) mem_data[tail][8*b +: 8] <= bus.cpu_wdata[8*b +: 8];
      mem_strb[tail] <= mem_strb[tail] | bus.cpu_wstrb;
    end
`endif
  end
endmodule

// File: tb/tb_uncache_wbuf.sv
// tb/tb_uncache_wbuf.sv - randomized bench for uncache_wbuf against an outstanding-store/load-phase model
module tb_uncache_wbuf;
  localparam int DEPTH = 4, ADDR_W = 32, DATA_W = 32, LT_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uncache_wbuf_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LT_W(LT_W)) bus ();
  uncache_wbuf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LT_W(LT_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  int n_cmp = 0;
  int n_bad = 0;

  wr_t         wq[$];   // stores accepted but not yet completed, oldest first
  bit          w_busy;  // oldest store handed to the bus, awaiting completion
  int          ld;      // 0 none, 1 address phase, 2 data phase, 3 returning to cpu
  bit          ld_drop;
  logic [31:0] ld_a, ld_d;
  logic [2:0]  ld_t;
  bit          st_prev;
  bit          stall;
  bit          quiet;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    wq.delete();
    w_busy = 0; ld = 0; ld_drop = 0; st_prev = 0;
  endtask

  task automatic zero_inputs();
    bus.cpu_valid = 0; bus.cpu_op = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.cpu_wstrb = '0; bus.cpu_loadType = '0; bus.cpu_flush = 0;
    bus.rd_rdy = 0; bus.ret_valid = 0; bus.ret_data = '0; bus.wr_rdy = 0; bus.wr_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    zero_inputs();
    rst = 1'b1;
    #2;
    check("rst_addr_ok", 64'(bus.cpu_addr_ok), 64'(0));
    check("rst_data_ok", 64'(bus.cpu_data_ok), 64'(0));
    check("rst_rd_req",  64'(bus.rd_req),      64'(0));
    check("rst_wr_req",  64'(bus.wr_req),      64'(0));
    check("rst_rdata",   64'(bus.cpu_rdata),   64'(0));
    check("rst_rd_addr", 64'(bus.rd_addr),     64'(0));
    check("rst_empty",   64'(bus.empty),       64'(1));
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic drive();
    if (quiet) begin
      zero_inputs();
      bus.rd_rdy = 1; bus.wr_rdy = 1;
      bus.wr_valid = w_busy;
      bus.ret_valid = (ld == 2);
      bus.ret_data = $urandom;
    end else begin
      bus.cpu_valid    = ($urandom_range(3) != 0);
      bus.cpu_op       = 1'($urandom_range(1));
      bus.cpu_addr     = $urandom;
      bus.cpu_wdata    = $urandom;
      bus.cpu_wstrb    = 4'($urandom_range(15));
      bus.cpu_loadType = 3'($urandom_range(7));
      bus.cpu_flush    = ($urandom_range(9) == 0);
      bus.rd_rdy       = 1'($urandom_range(1));
      bus.wr_rdy       = !stall && ($urandom_range(1) != 0);
      bus.ret_valid    = (ld == 2) && ($urandom_range(1) != 0);
      bus.ret_data     = $urandom;
      bus.wr_valid     = w_busy && !stall && ($urandom_range(1) != 0);
    end
  endtask

  task automatic step();
    bit exp_st, exp_ld, exp_dok, pop_now, wr_hs;
    @(negedge clk);
    drive();
    #2;
    pop_now = bus.wr_valid;
    exp_st  = bus.cpu_valid && bus.cpu_op && !bus.cpu_flush && (ld == 0) &&
              ((wq.size() < DEPTH) || pop_now);
    exp_ld  = bus.cpu_valid && !bus.cpu_op && !bus.cpu_flush && (ld == 0) && (wq.size() == 0);
    exp_dok = (st_prev && !bus.cpu_flush) || (ld == 3);
    check("addr_ok", 64'(bus.cpu_addr_ok), 64'(exp_st || exp_ld));
    check("data_ok", 64'(bus.cpu_data_ok), 64'(exp_dok));
    check("rd_req",  64'(bus.rd_req),      64'(ld == 1));
    check("empty",   64'(bus.empty),       64'(wq.size() == 0));
    check("rd_wr_excl", 64'(bus.rd_req && bus.wr_req), 64'(0));
    if (ld == 1) begin
      check("rd_addr",  64'(bus.rd_addr),  64'(ld_a));
      check("loadType", 64'(bus.loadType), 64'(ld_t));
    end
    if (ld == 3) check("cpu_rdata", 64'(bus.cpu_rdata), 64'(ld_d));
    if (bus.wr_req) begin
      check("wr_req_while_busy", 64'(w_busy), 64'(0));
      if (wq.size() == 0) check("wr_req_no_store", 64'(bus.wr_req), 64'(0));
      else begin
        check("wr_addr",  64'(bus.wr_addr),  64'(wq[0].a));
        check("wr_data",  64'(bus.wr_data),  64'(wq[0].d));
        check("wr_wstrb", 64'(bus.wr_wstrb), 64'(wq[0].s));
      end
    end
    wr_hs = bus.wr_req && bus.wr_rdy;
    @(posedge clk);
    if (pop_now && wq.size() != 0) begin
      void'(wq.pop_front());
      w_busy = 0;
    end
    if (wr_hs) w_busy = 1;
    if (exp_st) wq.push_back({bus.cpu_addr, bus.cpu_wdata, bus.cpu_wstrb});
    st_prev = exp_st;
    case (ld)
      0: if (exp_ld) begin ld = 1; ld_a = bus.cpu_addr; ld_t = bus.cpu_loadType; end
      1: begin
        if (bus.rd_rdy) begin ld = 2; ld_drop = bus.cpu_flush; end
        else if (bus.cpu_flush) ld = 0;
      end
      2: begin
        if (bus.cpu_flush) ld_drop = 1;
        if (bus.ret_valid) begin ld_d = bus.ret_data; ld = ld_drop ? 0 : 3; end
      end
      default: ld = 0;
    endcase
  endtask

  initial begin
    int guard;
    zero_inputs();
    clear_model();
    stall = 0;
    quiet = 0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      stall = ((c / 150) % 4 == 3);
      if (c == 2000) do_reset();
      step();
    end
    stall = 0;
    quiet = 1;
    guard = 0;
    while ((wq.size() != 0 || ld != 0) && guard < 300) begin
      step();
      guard++;
    end
    check("drain_in_time", 64'(guard < 300), 64'(1));
    step();
    check("drain_empty", 64'(bus.empty), 64'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
